// File: rtl/uart_stream_filter.sv
// Purpose: pops RX FIFO words, filters them (pass / moving average / first difference), pushes results to TX FIFO; FILTER_STATS_EN adds counters.
// Latency: push strobe 2 cycles after the pop strobe when the TX FIFO has room; one word in flight at a time.
// Backpressure: TX full holds the result in WRITE and blocks further pops until the push completes.
module uart_stream_filter #(
    parameter int DBITS   = 8,
    parameter int TAP_EXP = 2
) (
    input  logic             clk_100MHz,
    input  logic             reset_btn,
    input  logic             rx_empty,
    input  logic [DBITS-1:0] rx_data,
    output logic             rd_en,
    input  logic             tx_full,
    output logic             wr_en,
    output logic [DBITS-1:0] tx_data,
    input  logic [1:0]       mode,
    input  logic             filt_clr,
    output logic             busy
`ifdef FILTER_STATS_EN
    ,
    output logic [15:0]      sample_count,
    output logic [15:0]      stall_count
`endif
);

    localparam int TAPS = 1 << TAP_EXP;
    localparam int SW   = DBITS + TAP_EXP;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [1:0] M_PASS0 = 2'b00;
    localparam logic [1:0] M_AVG   = 2'b01;
    localparam logic [1:0] M_DIFF  = 2'b10;

    logic [1:0]                 r_state;
    logic [DBITS-1:0]           r_sample;
    logic [1:0]                 r_mode;
    logic [DBITS-1:0]           r_out;
    logic [DBITS-1:0]           r_prev;
    logic [SW-1:0]              r_sum;
    logic [TAPS-1:0][DBITS-1:0] r_hist;

    logic [SW-1:0]              w_sum_next;
    logic [DBITS-1:0]           w_avg;
    logic [DBITS-1:0]           w_diff;
    logic [DBITS-1:0]           w_result;
    logic                       w_idle;
    logic                       w_write;

    assign w_idle  = (r_state == S_IDLE);
    assign w_write = (r_state == S_WRITE);

    // Reset is gated in so the strobes stay low while reset_btn is held.
    assign rd_en   = w_idle & ~rx_empty & ~filt_clr & ~reset_btn;
    assign wr_en   = w_write & ~tx_full & ~reset_btn;
    assign tx_data = r_out;
    assign busy    = ~w_idle;

    // Sum never drops below the oldest tap, so the subtraction cannot underflow.
    assign w_sum_next = r_sum + {{TAP_EXP{1'b0}}, r_sample}
                              - {{TAP_EXP{1'b0}}, r_hist[TAPS-1]};
    assign w_avg      = w_sum_next[SW-1:TAP_EXP];
    assign w_diff     = r_sample - r_prev;

    always_comb begin
        w_result = r_sample;
        case (r_mode)
            M_AVG:   w_result = w_avg;
            M_DIFF:  w_result = w_diff;
            M_PASS0: w_result = r_sample;
            default: w_result = r_sample;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset_btn) begin
        if (reset_btn) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_mode   <= '0;
            r_out    <= '0;
            r_prev   <= '0;
            r_sum    <= '0;
            r_hist   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (filt_clr) begin
                        r_hist <= '0;
                        r_sum  <= '0;
                        r_prev <= '0;
                    end else if (!rx_empty) begin
                        r_sample <= rx_data;
                        r_mode   <= mode;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // History tracks every sample so switching modes has no warm-up transient.
                    r_hist  <= {r_hist[TAPS-2:0], r_sample};
                    r_sum   <= w_sum_next;
                    r_prev  <= r_sample;
                    r_out   <= w_result;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!tx_full) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FILTER_STATS_EN
    logic [15:0] r_sample_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk_100MHz or posedge reset_btn) begin
        if (reset_btn) begin
            r_sample_count <= '0;
            r_stall_count  <= '0;
        end else begin
            if (w_write && !tx_full) begin
                r_sample_count <= r_sample_count + 16'd1;
            end
            if (w_write && tx_full) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign sample_count = r_sample_count;
    assign stall_count  = r_stall_count;
`endif

endmodule

// File: tb/tb_uart_stream_filter.sv
// Scoreboard bench for uart_stream_filter: directed words with hand-computed results.
module tb_uart_stream_filter;

    logic       clk_100MHz = 1'b0;
    logic       reset_btn  = 1'b1;
    logic       rx_empty   = 1'b1;
    logic [7:0] rx_data    = 8'h00;
    logic       rd_en;
    logic       tx_full    = 1'b0;
    logic       wr_en;
    logic [7:0] tx_data;
    logic [1:0] mode       = 2'b00;
    logic       filt_clr   = 1'b0;
    logic       busy;
`ifdef FILTER_STATS_EN
    logic [15:0] sample_count;
    logic [15:0] stall_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    int cyc     = 0;
    int rd_cyc  = 0;
    bit stalled = 1'b0;

    uart_stream_filter #(.DBITS(8), .TAP_EXP(2)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_btn  (reset_btn),
        .rx_empty   (rx_empty),
        .rx_data    (rx_data),
        .rd_en      (rd_en),
        .tx_full    (tx_full),
        .wr_en      (wr_en),
        .tx_data    (tx_data),
        .mode       (mode),
        .filt_clr   (filt_clr),
        .busy       (busy)
`ifdef FILTER_STATS_EN
        ,
        .sample_count (sample_count),
        .stall_count  (stall_count)
`endif
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every push and checks the 2-cycle latency.
    always @(negedge clk_100MHz) begin
        cyc++;
        if (!reset_btn) begin
            if (busy && tx_full) stalled = 1'b1;
            if (rd_en) rd_cyc = cyc;
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_push: got %0h, required no push", tx_data);
                end else begin
                    chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                    if (!stalled) chk("push_latency", cyc - rd_cyc, 2);
                    stalled = 1'b0;
                end
            end
        end
    end

    // All driver tasks start and end at posedge+1 so negedge samples are stable.
    task automatic pop_wait();
        bit done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk_100MHz);
            if (rd_en) done = 1'b1;
            @(posedge clk_100MHz);
            #1;
        end
        rx_empty = 1'b1;
        if (!done) chk("pop_timeout", 0, 1);
    endtask

    task automatic push_word(input logic [7:0] d, input logic [1:0] m, input logic [7:0] e);
        exp_q.push_back(e);
        rx_data  = d;
        mode     = m;
        rx_empty = 1'b0;
        pop_wait();
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk_100MHz);
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        @(posedge clk_100MHz);
        #1;
        if (!done) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_btn = 1'b1;
        rx_empty  = 1'b0;
        rx_data   = 8'hAA;
        @(negedge clk_100MHz);
        chk("rst_rd_en", {31'd0, rd_en}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        @(posedge clk_100MHz);
        #1;
        rx_empty  = 1'b1;
        reset_btn = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk_100MHz);
        #1;
        do_reset();

        // Pass-through, modes 00 and 11.
        push_word(8'h41, 2'b00, 8'h41);
        push_word(8'h7E, 2'b11, 8'h7E);
        drain();

        // Moving average over 4 taps starting from zero history.
        do_reset();
        push_word(8'h10, 2'b01, 8'h04);
        push_word(8'h20, 2'b01, 8'h0C);
        push_word(8'h30, 2'b01, 8'h18);
        push_word(8'h40, 2'b01, 8'h28);
        push_word(8'h50, 2'b01, 8'h38);
        drain();

        // First difference, wrap, and a mode change after the pop.
        do_reset();
        push_word(8'h05, 2'b10, 8'h05);
        push_word(8'h03, 2'b10, 8'hFE);
        push_word(8'h09, 2'b00, 8'h09);
        mode = 2'b10;
        push_word(8'h0A, 2'b10, 8'h01);
        drain();

        // TX full for 10 WRITE cycles with a second word waiting.
        do_reset();
        tx_full = 1'b1;
        push_word(8'h5A, 2'b00, 8'h5A);
        exp_q.push_back(8'h33);
        rx_data  = 8'h33;
        mode     = 2'b00;
        rx_empty = 1'b0;
        @(posedge clk_100MHz);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100MHz);
            chk("stall_wr_en", {31'd0, wr_en}, 0);
            chk("stall_tx_data", {24'd0, tx_data}, 32'h5A);
            chk("stall_rd_en", {31'd0, rd_en}, 0);
            @(posedge clk_100MHz);
            #1;
        end
        tx_full = 1'b0;
        pop_wait();
        drain();
`ifdef FILTER_STATS_EN
        chk("stall_count", {16'd0, stall_count}, 10);
        chk("sample_count", {16'd0, sample_count}, 2);
`endif

        // Reset during CALC discards the in-flight sample and the history.
        do_reset();
        push_word(8'h10, 2'b01, 8'h04);
        push_word(8'h20, 2'b01, 8'h0C);
        drain();
        rx_data  = 8'h30;
        mode     = 2'b01;
        rx_empty = 1'b0;
        @(negedge clk_100MHz);
        chk("pre_rst_rd_en", {31'd0, rd_en}, 1);
        @(posedge clk_100MHz);
        #1;
        rx_empty  = 1'b1;
        chk("calc_busy", {31'd0, busy}, 1);
        reset_btn = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_tx_data", {24'd0, tx_data}, 0);
        @(posedge clk_100MHz);
        #1;
        reset_btn = 1'b0;
        push_word(8'h80, 2'b01, 8'h20);
        push_word(8'h20, 2'b01, 8'h28);
        drain();

        // History clear in IDLE blocks the pop for that cycle.
        filt_clr = 1'b1;
        rx_data  = 8'h40;
        mode     = 2'b01;
        rx_empty = 1'b0;
        @(negedge clk_100MHz);
        chk("clr_rd_en", {31'd0, rd_en}, 0);
        @(posedge clk_100MHz);
        #1;
        filt_clr = 1'b0;
        exp_q.push_back(8'h10);
        pop_wait();
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_stream_filter.md
UART_STREAM_FILTER -- requirements
Module: uart_stream_filter

Interface
REQ-001 Parameter DBITS, default 8, data word width in bits.
REQ-002 Parameter TAP_EXP, default 2, log2 of the moving-average tap count (TAPS = 2^TAP_EXP), legal range 1..4.
REQ-003 clk_100MHz  in  1  system clock; all state updates on its rising edge.
REQ-004 reset_btn  in  1  asynchronous, active-high reset.
REQ-005 rx_empty  in  1  RX FIFO empty flag.
REQ-006 rx_data  in  DBITS  RX FIFO head word, valid whenever rx_empty=0.
REQ-007 rd_en  out  1  RX FIFO pop strobe.
REQ-008 tx_full  in  1  TX FIFO full flag.
REQ-009 wr_en  out  1  TX FIFO push strobe.
REQ-010 tx_data  out  DBITS  word to push, valid while wr_en=1.
REQ-011 mode  in  2  filter select: 00 pass, 01 moving average, 10 first difference, 11 pass.
REQ-012 filt_clr  in  1  synchronous history clear request.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, CALC, WRITE; transitions IDLE->CALC on a pop, CALC->WRITE unconditionally, WRITE->IDLE on a push, WRITE->WRITE while tx_full=1.
REQ-015 rd_en = (state==IDLE) & ~rx_empty & ~filt_clr, combinational; at the same edge, rx_data is captured into sample_reg and mode into mode_reg.
REQ-016 Each pop produces exactly one push; at most one pop per 3 cycles; no pop while busy.
REQ-017 CALC: history shift register (TAPS x DBITS) shifts in sample_reg; running sum (DBITS+TAP_EXP bits) updated as sum + new - oldest; the result is registered into out_reg.
REQ-018 The history and sum update on every sample regardless of mode_reg, so a mode change takes effect without transient.
REQ-019 Mode 00/11: out_reg = sample_reg.
REQ-020 Mode 01: out_reg = updated sum >> TAP_EXP (truncating); zero history counts as samples.
REQ-021 Mode 10: out_reg = (sample_reg - previous sample) mod 2^DBITS; previous = 0 after reset or clear.
REQ-022 wr_en = (state==WRITE) & ~tx_full, combinational; tx_data = out_reg, held stable throughout WRITE.
REQ-023 With tx_full=0, wr_en asserts exactly 2 cycles after the rd_en cycle.
REQ-024 tx_full=1 in WRITE: wr_en=0, out_reg held, no pop; one push on the first cycle tx_full=0.
REQ-025 filt_clr=1 in IDLE: history, sum and previous sample zeroed at the edge, no pop that cycle; filt_clr is ignored in CALC/WRITE.
REQ-026 mode changes while busy do not affect the in-flight sample.

Reset
REQ-027 Asserting reset_btn at any time, including mid-CALC/WRITE, forces state=IDLE and zeroes sample_reg, mode_reg, out_reg, history, sum and previous sample; any in-flight sample is discarded.
REQ-028 During reset: rd_en=0, wr_en=0, tx_data=0, busy=0.

Configuration
REQ-029 Macro FILTER_STATS_EN defined: ports sample_count[15:0] (increments per push) and stall_count[15:0] (increments per WRITE cycle with tx_full=1) exist; both wrap at 0xFFFF->0 and reset to 0.
REQ-030 FILTER_STATS_EN undefined: those ports and counters are absent; all other behaviour identical.

Verification (DBITS=8, TAP_EXP=2)
REQ-031 mode=00, rx_data=0x41 -> one rd_en pulse; wr_en 2 cycles later with tx_data=0x41.
REQ-032 mode=01 after reset, words 0x10,0x20,0x30,0x40,0x50 -> tx_data 0x04,0x0C,0x18,0x28,0x38.
REQ-033 mode=10 after reset, words 0x05,0x03 -> tx_data 0x05, 0xFE.
REQ-034 tx_full=1 for 10 cycles during WRITE -> wr_en=0 and tx_data stable, no rd_en; one wr_en on release; stall_count=10 with FILTER_STATS_EN.
REQ-035 reset_btn pulsed in CALC after 0x10,0x20,0x30 in mode 01, then 0x80 -> only 0x04,0x0C emitted before reset, then tx_data 0x20.
REQ-036 filt_clr=1 in IDLE with rx_empty=0 -> no rd_en that cycle; next mode-01 word 0x40 -> 0x10.
